// File: rtl/shift_pkg.sv
// Shared shift-type encodings and sequencer state encoding for the shifter blocks.
package shift_pkg;

  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;
  localparam logic [1:0] SHIFT_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_seq_unit_step.sv
// Combinational single-step shifter: moves the working value by 1 or 4 bits
// with SLL/SRL/SRA fill rules; the reserved type passes the value through.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       shift_type,
  input  logic             step4,
  output logic [WIDTH-1:0] next_value
);

  logic [2:0] amt;

  assign amt = step4 ? 3'd4 : 3'd1;

  always_comb begin
    next_value = value;
    case (shift_type)
      SHIFT_SLL: next_value = value << amt;
      SHIFT_SRL: next_value = value >> amt;
      SHIFT_SRA: next_value = $signed(value) >>> amt;
      default:   next_value = value;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Iterative shifter: one start-qualified request, shifted one bit per cycle,
// result returned with a one-cycle done pulse. SHIFT_SEQ_STEP4_EN enables 4-bit steps.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int AMNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [1:0]        shift_type,
  input  logic [AMNT_W-1:0] shift_amnt,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [AMNT_W-1:0]  count_q, count_d;
  logic [1:0]         type_q, type_d;
  logic               done_q, done_d;

  logic               step4;
  logic [AMNT_W-1:0]  step_amt;
  logic [AMNT_W-1:0]  count_next;
  logic [WIDTH-1:0]   step_value;

`ifdef SHIFT_SEQ_STEP4_EN
  assign step4 = (count_q >= AMNT_W'(4));
`else
  assign step4 = 1'b0;
`endif

  assign step_amt   = step4 ? AMNT_W'(4) : AMNT_W'(1);
  assign count_next = count_q - step_amt;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .value      (work_q),
    .shift_type (type_q),
    .step4      (step4),
    .next_value (step_value)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    count_d  = count_q;
    type_d   = type_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = a_in;
          type_d  = shift_type;
          count_d = shift_amnt;
          // Zero amount and reserved type skip SHIFT and return a_in unchanged
          if (shift_amnt == '0 || shift_type == SHIFT_RSV) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d  = step_value;
        count_d = count_next;
        if (count_next == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        result_d = work_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      type_q   <= SHIFT_SLL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      count_q  <= count_d;
      type_q   <= type_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: expected result and done cycle are queued
// at acceptance and checked when done pulses.
module tb_shift_seq_unit;

  localparam int WIDTH  = 32;
  localparam int AMNT_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  a_in = '0;
  logic [1:0]        shift_type = 2'b00;
  logic [AMNT_W-1:0] shift_amnt = '0;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  shift_seq_unit #(
    .WIDTH  (WIDTH),
    .AMNT_W (AMNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .shift_type (shift_type),
    .shift_amnt (shift_amnt),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelShift(input logic [31:0] a, input logic [1:0] t, input int n);
    case (t)
      2'b00:   return a << n;
      2'b01:   return a >> n;
      2'b10:   return $signed(a) >>> n;
      default: return a;
    endcase
  endfunction

  function automatic int modelLatency(input logic [1:0] t, input int n);
    if (t == 2'b11 || n == 0) return 1;
`ifdef SHIFT_SEQ_STEP4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Drives one request, pushes its expectation at the acceptance edge
  task automatic applyStimulus(input logic [31:0] a, input logic [1:0] t, input int n, input logic [31:0] exp_res);
    exp_t e;
    a_in       = a;
    shift_type = t;
    shift_amnt = AMNT_W'(n);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    e.res      = exp_res;
    e.done_cyc = cyc + modelLatency(t, n);
    sb.push_back(e);
    checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
    a_in       = $urandom;
    shift_type = 2'($urandom_range(0, 3));
    shift_amnt = AMNT_W'($urandom_range(0, 31));
  endtask

  task automatic pulseStart(input logic [31:0] a, input logic [1:0] t, input int n);
    a_in       = a;
    shift_type = t;
    shift_amnt = AMNT_W'(n);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) return;
    end
    checkOutput("timeout_pending", sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [1:0]  rt;
    int          rn;

    #2;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(32'd11, 2'b00, 2, 32'd44);
    waitIdle();
    applyStimulus(32'h8000_0000, 2'b10, 31, 32'hFFFF_FFFF);
    waitIdle();
    applyStimulus(32'h8000_0000, 2'b01, 31, 32'h0000_0001);
    waitIdle();
    applyStimulus(32'hDEAD_BEEF, 2'b10, 0, 32'hDEAD_BEEF);
    waitIdle();
    applyStimulus(32'hDEAD_BEEF, 2'b11, 7, 32'hDEAD_BEEF);
    waitIdle();

    // A start pulsed while busy must be dropped
    applyStimulus(32'd1, 2'b00, 4, 32'd16);
    @(negedge clk);
    pulseStart(32'hFFFF_FFFF, 2'b00, 1);
    waitIdle();
    applyStimulus(32'd5, 2'b01, 1, 32'd2);
    waitIdle();

    applyStimulus(32'd11, 2'b00, 6, 32'd704);
    waitIdle();

    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rt = 2'($urandom_range(0, 3));
      rn = $urandom_range(0, 31);
      applyStimulus(ra, rt, rn, modelShift(ra, rt, rn));
      waitIdle();
    end

    // Asynchronous reset mid-operation drops the request without a done pulse
    @(negedge clk);
    pulseStart(32'hF0F0_F0F0, 2'b01, 20);
    repeat (5) @(posedge clk);
    #3;
    checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("idle_after_reset", {31'd0, busy}, 32'd0);

    applyStimulus(32'd3, 2'b00, 3, 32'd24);
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
